mips_control_fsm: RTL and testbench
===================================

MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 SHALL have parameter STALL_W, default 16: width of the saturating stall-cycle counter.
REQ-002 SHALL have parameter DM_WAIT_EN, default 1: 1 = wait in DMWAIT for the mult/div unit; 0 = go straight from EXEC1 to EXEC2.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port opcode, input, 6: instruction [31:26].
REQ-006 SHALL have port fun, input, 6: instruction [5:0].
REQ-007 SHALL have port rt, input, 5: instruction [20:16], used for REGIMM decode.
REQ-008 SHALL have port addr_lo, input, 2: effective address [1:0].
REQ-009 SHALL have port waitrequest, input, 1: Avalon stall.
REQ-010 SHALL have port dm_busy, input, 1: mult/div unit busy.
REQ-011 SHALL have port halt_req, input, 1: next PC equals 0.
REQ-012 SHALL have port state, output, 4: current state.
REQ-013 SHALL have port active, output, 1: CPU running.
REQ-014 SHALL have ports alu_op[3:0], alu_src, jump, branch, memread, memwrite, regdst, memtoreg, regwrite, inwrite, pctoadd, pcwrite, regtojump, div_mult_en, div_mult_signed, div_mult_op[1:0], link, loadimmed, all output: datapath controls.
REQ-015 SHALL have port byteenable, output, 4: Avalon byte lanes.
REQ-016 SHALL have port stall_count, output, STALL_W: stall cycles counted since reset.
REQ-017 SHALL have port illegal, output, 1: sticky undecoded-instruction flag.

Function
REQ-018 SHALL own the state register, encoded HALT=0, FETCH=1, DECODE=2, EXEC1=3, EXEC2=4, DMWAIT=5; all control outputs are combinational from state and decode.
REQ-019 SHALL in FETCH assert memread=1 and pctoadd=1, hold while waitrequest=1, otherwise go to DECODE.
REQ-020 SHALL in DECODE assert inwrite=1 for exactly one cycle, then go to EXEC1.
REQ-021 SHALL in EXEC1 assert memread for loads (LB, LBU, LH, LHU, LW, LUI) and hold while memread&waitrequest.
REQ-022 SHALL in EXEC1 pulse div_mult_en once for MULT/MULTU/DIV/DIVU, then go to DMWAIT if DM_WAIT_EN, else to EXEC2.
REQ-023 SHALL in DMWAIT hold while dm_busy=1, then go to EXEC2.
REQ-024 SHALL in EXEC2 assert memwrite for SB/SH/SW and hold while memwrite&waitrequest.
REQ-025 SHALL in EXEC2 assert pcwrite=1 exactly on the leaving cycle; regwrite is gated the same way.
REQ-026 SHALL leave EXEC2 to HALT if halt_req=1 on the leaving cycle, otherwise to FETCH.
REQ-027 SHALL in HALT drive every strobe (memread, memwrite, regwrite, inwrite, pcwrite, div_mult_en) to 0 and active=0, and stay there until reset.
REQ-028 SHALL decode the full instruction set: arithmetic R-type, JR/JALR, mult/div, ADDIU/ANDI/ORI/XORI/SLTI/SLTIU, LUI, BEQ/BNE/BGTZ/BLEZ, REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL by rt, loads/stores, J/JAL.
REQ-029 SHALL assert link for JAL, JALR, BLTZAL and BGEZAL.
REQ-030 SHALL drive byteenable as: word = 1111; half = 0011 if addr_lo[1]=0, else 1100; byte = one-hot of addr_lo; all other cases 1111.
REQ-031 SHALL increment stall_count each cycle the state holds because of waitrequest or dm_busy, saturating at all-ones.
REQ-032 SHALL treat unlisted opcodes as NOP (no strobes).

Reset
REQ-033 SHALL on a reset edge set state=FETCH, active=1, stall_count=0 and illegal=0, so memread=1 on the first post-reset cycle.
REQ-034 SHALL let reset override every transition, including mid-stall and HALT.

Configuration
REQ-035 SHALL, with CONTROL_ILLEGAL_TRAP_EN defined, set illegal=1 and go to HALT from EXEC1 on an undecoded opcode or fun.
REQ-036 SHALL, without CONTROL_ILLEGAL_TRAP_EN, tie illegal to 0 and execute undecoded instructions as NOP.

Structure
REQ-037 SHALL place the state enum, opcode/fun/rt constants and ALU-op codes in package mips_pkg.
REQ-038 SHALL split combinational decode into sub-module mips_ctrl_decode; the FSM, stall counter and byteenable logic stay in the top module.

Verification
REQ-039 SHALL cover: ADDIU with waitrequest high 3 FETCH cycles -> stall_count=3, regwrite and pcwrite for one cycle in EXEC2.
REQ-040 SHALL cover: SB with addr_lo=2 -> byteenable=0100, memwrite held through 2 wait cycles, pcwrite on the release cycle.
REQ-041 SHALL cover: DIV with dm_busy high 5 cycles and DM_WAIT_EN=1 -> one div_mult_en pulse, 5 DMWAIT cycles; with DM_WAIT_EN=0 -> no DMWAIT.
REQ-042 SHALL cover: JR with halt_req=1 -> HALT, active=0, no further strobes.
REQ-043 SHALL cover: reset asserted during an EXEC1 load stall -> state=FETCH, stall_count=0 next cycle.
REQ-044 SHALL cover: opcode 111111 -> illegal=1 and HALT with the macro defined; NOP and return to FETCH without it.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit:
// FSM states, instruction field constants, ALU/mult-div codes and the decode bundle.
package mips_pkg;

   typedef enum logic [3:0] {
      S_HALT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC1  = 4'd3,
      S_EXEC2  = 4'd4,
      S_DMWAIT = 4'd5
   } state_t;

   // Primary opcodes, instruction [31:26]
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2B;

   // SPECIAL function codes, instruction [5:0]
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   // REGIMM selectors, instruction [20:16]
   localparam logic [4:0] RT_BLTZ   = 5'h00;
   localparam logic [4:0] RT_BGEZ   = 5'h01;
   localparam logic [4:0] RT_BLTZAL = 5'h10;
   localparam logic [4:0] RT_BGEZAL = 5'h11;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;

   localparam logic [1:0] DM_MULT = 2'b00;
   localparam logic [1:0] DM_DIV  = 2'b01;
   localparam logic [1:0] DM_MFHI = 2'b10;
   localparam logic [1:0] DM_MFLO = 2'b11;

   typedef enum logic [1:0] {
      SZ_NONE = 2'd0,
      SZ_BYTE = 2'd1,
      SZ_HALF = 2'd2,
      SZ_WORD = 2'd3
   } mem_size_t;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src;
      logic       jump;
      logic       branch;
      logic       load;
      logic       store;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       regtojump;
      logic       dm_start;
      logic       dm_signed;
      logic [1:0] dm_op;
      logic       link;
      logic       loadimmed;
      mem_size_t  mem_size;
      logic       known;
   } decode_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Purely combinational instruction decode: maps opcode/fun/rt to the static
// datapath controls; known=0 flags an instruction outside the supported set.
module mips_ctrl_decode
   import mips_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] fun,
   input  logic [4:0] rt,
   output decode_t    dec
);

   // NOTE: every field gets a default before the case so no path can infer a latch.
   always_comb begin
      dec       = '0;
      dec.known = 1'b1;
      case (opcode)
         OP_SPECIAL: begin
            dec.regdst   = 1'b1;
            dec.regwrite = 1'b1;
            case (fun)
               FN_SLL, FN_SLLV: dec.alu_op = ALU_SLL;
               FN_SRL, FN_SRLV: dec.alu_op = ALU_SRL;
               FN_SRA, FN_SRAV: dec.alu_op = ALU_SRA;
               FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
               FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
               FN_AND:          dec.alu_op = ALU_AND;
               FN_OR:           dec.alu_op = ALU_OR;
               FN_XOR:          dec.alu_op = ALU_XOR;
               FN_NOR:          dec.alu_op = ALU_NOR;
               FN_SLT:          dec.alu_op = ALU_SLT;
               FN_SLTU:         dec.alu_op = ALU_SLTU;
               FN_MFHI:         dec.dm_op  = DM_MFHI;
               FN_MFLO:         dec.dm_op  = DM_MFLO;
               FN_JR: begin
                  dec.regwrite  = 1'b0;
                  dec.regdst    = 1'b0;
                  dec.jump      = 1'b1;
                  dec.regtojump = 1'b1;
               end
               FN_JALR: begin
                  dec.jump      = 1'b1;
                  dec.regtojump = 1'b1;
                  dec.link      = 1'b1;
               end
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                  dec.regwrite  = 1'b0;
                  dec.regdst    = 1'b0;
                  dec.dm_start  = 1'b1;
                  dec.dm_signed = (fun == FN_MULT) || (fun == FN_DIV);
                  dec.dm_op     = ((fun == FN_MULT) || (fun == FN_MULTU)) ? DM_MULT : DM_DIV;
               end
               default: begin
                  dec.regwrite = 1'b0;
                  dec.regdst   = 1'b0;
                  dec.known    = 1'b0;
               end
            endcase
         end
         OP_REGIMM: begin
            dec.branch = 1'b1;
            dec.alu_op = ALU_SLT;
            case (rt)
               RT_BLTZ, RT_BGEZ: begin
               end
               RT_BLTZAL, RT_BGEZAL: begin
                  dec.link     = 1'b1;
                  dec.regwrite = 1'b1;
               end
               default: begin
                  dec.branch = 1'b0;
                  dec.alu_op = ALU_ADD;
                  dec.known  = 1'b0;
               end
            endcase
         end
         OP_J:   dec.jump = 1'b1;
         OP_JAL: begin
            dec.jump     = 1'b1;
            dec.link     = 1'b1;
            dec.regwrite = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            dec.branch = 1'b1;
            dec.alu_op = ALU_SUB;
         end
         OP_BLEZ, OP_BGTZ: begin
            dec.branch = 1'b1;
            dec.alu_op = ALU_SLT;
         end
         OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
            dec.alu_src  = 1'b1;
            dec.regwrite = 1'b1;
            case (opcode)
               OP_SLTI:  dec.alu_op = ALU_SLT;
               OP_SLTIU: dec.alu_op = ALU_SLTU;
               OP_ANDI:  dec.alu_op = ALU_AND;
               OP_ORI:   dec.alu_op = ALU_OR;
               OP_XORI:  dec.alu_op = ALU_XOR;
               default:  dec.alu_op = ALU_ADD;
            endcase
         end
         // LUI travels the load path so the immediate is captured in EXEC1
         OP_LUI: begin
            dec.alu_src   = 1'b1;
            dec.regwrite  = 1'b1;
            dec.loadimmed = 1'b1;
            dec.load      = 1'b1;
            dec.alu_op    = ALU_LUI;
            dec.mem_size  = SZ_WORD;
         end
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
            dec.alu_src  = 1'b1;
            dec.regwrite = 1'b1;
            dec.memtoreg = 1'b1;
            dec.load     = 1'b1;
            dec.mem_size = (opcode == OP_LW) ? SZ_WORD :
                           ((opcode == OP_LH) || (opcode == OP_LHU)) ? SZ_HALF : SZ_BYTE;
         end
         OP_SB, OP_SH, OP_SW: begin
            dec.alu_src  = 1'b1;
            dec.store    = 1'b1;
            dec.mem_size = (opcode == OP_SW) ? SZ_WORD :
                           (opcode == OP_SH) ? SZ_HALF : SZ_BYTE;
         end
         default: dec.known = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control FSM with stall counter and Avalon byte-lane generation.
// Build option CONTROL_ILLEGAL_TRAP_EN: undecoded instructions set a sticky flag and halt.
module mips_control_fsm
   import mips_pkg::*;
#(
   parameter int STALL_W    = 16,
   parameter int DM_WAIT_EN = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic [5:0]         fun,
   input  logic [4:0]         rt,
   input  logic [1:0]         addr_lo,
   input  logic               waitrequest,
   input  logic               dm_busy,
   input  logic               halt_req,
   output logic [3:0]         state,
   output logic               active,
   output logic [3:0]         alu_op,
   output logic               alu_src,
   output logic               jump,
   output logic               branch,
   output logic               memread,
   output logic               memwrite,
   output logic               regdst,
   output logic               memtoreg,
   output logic               regwrite,
   output logic               inwrite,
   output logic               pctoadd,
   output logic               pcwrite,
   output logic               regtojump,
   output logic               div_mult_en,
   output logic               div_mult_signed,
   output logic [1:0]         div_mult_op,
   output logic               link,
   output logic               loadimmed,
   output logic [3:0]         byteenable,
   output logic [STALL_W-1:0] stall_count,
   output logic               illegal
);

`ifdef CONTROL_ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   state_t             state_q, state_d;
   decode_t            dec;
   logic               hold;
   logic               trap_hit;
   logic               illegal_q;
   logic [STALL_W-1:0] stall_q;

   mips_ctrl_decode u_decode (
      .opcode (opcode),
      .fun    (fun),
      .rt     (rt),
      .dec    (dec)
   );

   assign trap_hit    = TRAP_EN && (state_q == S_EXEC1) && !dec.known;
   assign state       = state_q;
   assign active      = (state_q != S_HALT);
   assign stall_count = stall_q;
   assign illegal     = TRAP_EN & illegal_q;

   always_comb begin
      state_d         = state_q;
      hold            = 1'b0;
      memread         = 1'b0;
      memwrite        = 1'b0;
      regwrite        = 1'b0;
      inwrite         = 1'b0;
      pctoadd         = 1'b0;
      pcwrite         = 1'b0;
      div_mult_en     = 1'b0;
      alu_op          = ALU_ADD;
      alu_src         = 1'b0;
      jump            = 1'b0;
      branch          = 1'b0;
      regdst          = 1'b0;
      memtoreg        = 1'b0;
      regtojump       = 1'b0;
      div_mult_signed = 1'b0;
      div_mult_op     = DM_MULT;
      link            = 1'b0;
      loadimmed       = 1'b0;

      if (state_q != S_HALT) begin
         alu_op          = dec.alu_op;
         alu_src         = dec.alu_src;
         jump            = dec.jump;
         branch          = dec.branch;
         regdst          = dec.regdst;
         memtoreg        = dec.memtoreg;
         regtojump       = dec.regtojump;
         div_mult_signed = dec.dm_signed;
         div_mult_op     = dec.dm_op;
         link            = dec.link;
         loadimmed       = dec.loadimmed;
      end

      case (state_q)
         S_FETCH: begin
            memread = 1'b1;
            pctoadd = 1'b1;
            if (waitrequest) hold = 1'b1;
            else             state_d = S_DECODE;
         end
         S_DECODE: begin
            inwrite = 1'b1;
            state_d = S_EXEC1;
         end
         S_EXEC1: begin
            if (trap_hit) begin
               state_d = S_HALT;
            end else begin
               memread = dec.load;
               if (dec.load && waitrequest) begin
                  hold = 1'b1;
               end else begin
                  div_mult_en = dec.dm_start;
                  state_d     = (dec.dm_start && (DM_WAIT_EN != 0)) ? S_DMWAIT : S_EXEC2;
               end
            end
         end
         S_DMWAIT: begin
            if (dm_busy) hold = 1'b1;
            else         state_d = S_EXEC2;
         end
         // Architectural updates fire only on the cycle EXEC2 actually retires
         S_EXEC2: begin
            memwrite = dec.store;
            if (dec.store && waitrequest) begin
               hold = 1'b1;
            end else begin
               pcwrite  = 1'b1;
               regwrite = dec.regwrite;
               state_d  = halt_req ? S_HALT : S_FETCH;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   always_comb begin
      case (dec.mem_size)
         SZ_HALF: byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
         SZ_BYTE: byteenable = 4'b0001 << addr_lo;
         default: byteenable = 4'b1111;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         stall_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (hold && (stall_q != '1)) stall_q <= stall_q + STALL_W'(1);
         if (trap_hit) illegal_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed self-checking bench for mips_control_fsm; a second instance runs
// with DM_WAIT_EN=0 and a 2-bit stall counter for the bypass and saturation cases.
module tb_mips_control_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = '0;
   logic [5:0] fun = '0;
   logic [4:0] rt = '0;
   logic [1:0] addr_lo = '0;
   logic       waitrequest = 1'b0;
   logic       dm_busy = 1'b0;
   logic       halt_req = 1'b0;

   logic [3:0]  state, alu_op, byteenable;
   logic        active, alu_src, jump, branch, memread, memwrite, regdst, memtoreg;
   logic        regwrite, inwrite, pctoadd, pcwrite, regtojump, div_mult_en;
   logic        div_mult_signed, link, loadimmed, illegal;
   logic [1:0]  div_mult_op;
   logic [15:0] stall_count;

   logic [3:0]  nw_state, nw_alu_op, nw_byteenable;
   logic        nw_active, nw_alu_src, nw_jump, nw_branch, nw_memread, nw_memwrite, nw_regdst;
   logic        nw_memtoreg, nw_regwrite, nw_inwrite, nw_pctoadd, nw_pcwrite, nw_regtojump;
   logic        nw_div_mult_en, nw_div_mult_signed, nw_link, nw_loadimmed, nw_illegal;
   logic [1:0]  nw_div_mult_op;
   logic [1:0]  nw_stall_count;

   int n_cmp = 0;
   int n_err = 0;
   int dm_pulses = 0;
   int nw_dm_pulses = 0;
   int nw_dmwait_cycles = 0;
   int strobe_hits = 0;

   always #5 clk = ~clk;

   mips_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .fun(fun), .rt(rt), .addr_lo(addr_lo),
      .waitrequest(waitrequest), .dm_busy(dm_busy), .halt_req(halt_req),
      .state(state), .active(active), .alu_op(alu_op), .alu_src(alu_src), .jump(jump),
      .branch(branch), .memread(memread), .memwrite(memwrite), .regdst(regdst),
      .memtoreg(memtoreg), .regwrite(regwrite), .inwrite(inwrite), .pctoadd(pctoadd),
      .pcwrite(pcwrite), .regtojump(regtojump), .div_mult_en(div_mult_en),
      .div_mult_signed(div_mult_signed), .div_mult_op(div_mult_op), .link(link),
      .loadimmed(loadimmed), .byteenable(byteenable), .stall_count(stall_count),
      .illegal(illegal)
   );

   mips_control_fsm #(.STALL_W(2), .DM_WAIT_EN(0)) dut_nw (
      .clk(clk), .reset(reset), .opcode(opcode), .fun(fun), .rt(rt), .addr_lo(addr_lo),
      .waitrequest(waitrequest), .dm_busy(dm_busy), .halt_req(halt_req),
      .state(nw_state), .active(nw_active), .alu_op(nw_alu_op), .alu_src(nw_alu_src),
      .jump(nw_jump), .branch(nw_branch), .memread(nw_memread), .memwrite(nw_memwrite),
      .regdst(nw_regdst), .memtoreg(nw_memtoreg), .regwrite(nw_regwrite),
      .inwrite(nw_inwrite), .pctoadd(nw_pctoadd), .pcwrite(nw_pcwrite),
      .regtojump(nw_regtojump), .div_mult_en(nw_div_mult_en),
      .div_mult_signed(nw_div_mult_signed), .div_mult_op(nw_div_mult_op), .link(nw_link),
      .loadimmed(nw_loadimmed), .byteenable(nw_byteenable), .stall_count(nw_stall_count),
      .illegal(nw_illegal)
   );

   // Event tallies sampled mid-cycle, read as deltas by the stimulus
   always @(negedge clk) begin
      if (div_mult_en)            dm_pulses++;
      if (nw_div_mult_en)         nw_dm_pulses++;
      if (nw_state == 4'd5)       nw_dmwait_cycles++;
      if (memread | memwrite | regwrite | inwrite | pcwrite | div_mult_en) strobe_hits++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic start(input logic [5:0] op, input logic [5:0] fn);
      opcode = op;
      fun    = fn;
      do_reset();
   endtask

   task automatic lanes(input string tag, input logic [5:0] op, input logic [1:0] a,
                        input logic [3:0] exp);
      opcode  = op;
      addr_lo = a;
      #1;
      check(tag, byteenable, exp);
   endtask

   task automatic flow(input string tag, input logic [5:0] op, input logic [4:0] r,
                       input logic [5:0] fn, input logic [3:0] exp);
      opcode = op;
      rt     = r;
      fun    = fn;
      #1;
      check(tag, {jump, branch, link, regtojump}, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, s1, s2;

      // Reset state and ADDIU with three fetch wait cycles
      start(6'h09, 6'h00);
      check("rst_state",   state, 4'd1);
      check("rst_active",  active, 1);
      check("rst_memread", memread, 1);
      check("rst_pctoadd", pctoadd, 1);
      check("rst_stall",   stall_count, 0);
      check("rst_illegal", illegal, 0);
      waitrequest = 1'b1;
      repeat (3) cyc();
      check("addiu_fetch_hold", state, 4'd1);
      check("addiu_stall3", stall_count, 3);
      waitrequest = 1'b0;
      cyc();
      check("addiu_decode", state, 4'd2);
      check("addiu_inwrite", inwrite, 1);
      cyc();
      check("addiu_exec1", state, 4'd3);
      check("addiu_inwrite_once", inwrite, 0);
      cyc();
      check("addiu_exec2", state, 4'd4);
      check("addiu_regwrite", regwrite, 1);
      check("addiu_pcwrite", pcwrite, 1);
      check("addiu_alu_src", alu_src, 1);
      cyc();
      check("addiu_back_fetch", state, 4'd1);
      check("addiu_regwrite_off", regwrite, 0);
      check("addiu_pcwrite_off", pcwrite, 0);

      // SB to lane 2 with two write wait cycles
      start(6'h28, 6'h00);
      addr_lo = 2'd2;
      repeat (3) cyc();
      waitrequest = 1'b1;
      #1;
      check("sb_state", state, 4'd4);
      check("sb_lanes", byteenable, 4'b0100);
      check("sb_memwrite0", memwrite, 1);
      check("sb_pcwrite_wait0", pcwrite, 0);
      cyc();
      check("sb_hold", state, 4'd4);
      check("sb_memwrite1", memwrite, 1);
      check("sb_pcwrite_wait1", pcwrite, 0);
      cyc();
      waitrequest = 1'b0;
      #1;
      check("sb_memwrite2", memwrite, 1);
      check("sb_pcwrite_release", pcwrite, 1);
      check("sb_no_regwrite", regwrite, 0);
      check("sb_stall2", stall_count, 2);
      cyc();
      check("sb_done", state, 4'd1);

      // DIV: DMWAIT for five busy cycles; bypass instance skips DMWAIT
      start(6'h00, 6'h1A);
      s0 = dm_pulses;
      s1 = nw_dm_pulses;
      s2 = nw_dmwait_cycles;
      cyc();
      cyc();
      check("div_exec1", state, 4'd3);
      check("div_en", div_mult_en, 1);
      check("div_signed", div_mult_signed, 1);
      check("div_op", div_mult_op, 2'b01);
      check("nw_div_en", nw_div_mult_en, 1);
      dm_busy = 1'b1;
      cyc();
      check("nw_div_to_exec2", nw_state, 4'd4);
      check("nw_div_pulses", nw_dm_pulses - s1, 1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("div_dmwait_busy%0d", i), state, 4'd5);
         check($sformatf("div_en_quiet%0d", i), div_mult_en, 0);
         cyc();
      end
      dm_busy = 1'b0;
      #1;
      check("div_dmwait_release", state, 4'd5);
      cyc();
      check("div_exec2", state, 4'd4);
      check("div_pcwrite", pcwrite, 1);
      check("div_no_regwrite", regwrite, 0);
      check("div_stall5", stall_count, 5);
      check("div_pulses", dm_pulses - s0, 1);
      check("nw_no_dmwait", nw_dmwait_cycles - s2, 0);

      // JR retiring with halt_req: HALT with all strobes quiet
      start(6'h00, 6'h08);
      repeat (3) cyc();
      check("jr_exec2", state, 4'd4);
      check("jr_regtojump", regtojump, 1);
      check("jr_jump", jump, 1);
      halt_req = 1'b1;
      cyc();
      halt_req = 1'b0;
      #1;
      check("jr_halt", state, 4'd0);
      check("jr_inactive", active, 0);
      check("jr_memread_off", memread, 0);
      check("jr_pctoadd_off", pctoadd, 0);
      s0 = strobe_hits;
      repeat (3) cyc();
      check("jr_halt_stays", state, 4'd0);
      check("jr_no_strobes", strobe_hits - s0, 0);
      do_reset();
      check("halt_reset_state", state, 4'd1);
      check("halt_reset_active", active, 1);

      // Reset in the middle of an EXEC1 load stall
      start(6'h23, 6'h00);
      addr_lo = 2'd0;
      waitrequest = 1'b1;
      cyc();
      waitrequest = 1'b0;
      cyc();
      cyc();
      waitrequest = 1'b1;
      #1;
      check("lw_exec1", state, 4'd3);
      check("lw_memread", memread, 1);
      cyc();
      check("lw_exec1_hold", state, 4'd3);
      check("lw_stall2", stall_count, 2);
      do_reset();
      check("lw_reset_state", state, 4'd1);
      check("lw_reset_stall", stall_count, 0);
      check("lw_reset_memread", memread, 1);
      waitrequest = 1'b0;

      // Saturation of the 2-bit counter; decode-driven lanes and flow controls
      do_reset();
      waitrequest = 1'b1;
      repeat (5) cyc();
      check("sat_wide", stall_count, 5);
      check("sat_narrow", nw_stall_count, 2'b11);
      lanes("be_lb_a3",   6'h20, 2'd3, 4'b1000);
      lanes("be_lbu_a0",  6'h24, 2'd0, 4'b0001);
      lanes("be_lh_a2",   6'h21, 2'd2, 4'b1100);
      lanes("be_lhu_a0",  6'h25, 2'd0, 4'b0011);
      lanes("be_sh_a1",   6'h29, 2'd1, 4'b0011);
      lanes("be_lw_a1",   6'h23, 2'd1, 4'b1111);
      lanes("be_addiu",   6'h09, 2'd1, 4'b1111);
      flow("flow_jal",    6'h03, 5'h00, 6'h00, 4'b1010);
      flow("flow_j",      6'h02, 5'h00, 6'h00, 4'b1000);
      flow("flow_beq",    6'h04, 5'h00, 6'h00, 4'b0100);
      flow("flow_bltz",   6'h01, 5'h00, 6'h00, 4'b0100);
      flow("flow_bltzal", 6'h01, 5'h10, 6'h00, 4'b0110);
      flow("flow_bgezal", 6'h01, 5'h11, 6'h00, 4'b0110);
      flow("flow_jalr",   6'h00, 5'h00, 6'h09, 4'b1011);
      rt = 5'h00;
      waitrequest = 1'b0;

      // Opcode 111111
      start(6'h3F, 6'h00);
      cyc();
      cyc();
      check("ill_exec1_no_memread", memread, 0);
      cyc();
`ifdef CONTROL_ILLEGAL_TRAP_EN
      check("ill_halt", state, 4'd0);
      check("ill_flag", illegal, 1);
      check("ill_inactive", active, 0);
      do_reset();
      check("ill_flag_cleared", illegal, 0);
`else
      check("ill_nop_exec2", state, 4'd4);
      check("ill_flag_low", illegal, 0);
      check("ill_nop_pcwrite", pcwrite, 1);
      check("ill_nop_regwrite", regwrite, 0);
      check("ill_nop_memwrite", memwrite, 0);
      cyc();
      check("ill_nop_fetch", state, 4'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
